// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory and the benches
// that build program images for it.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_e;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h31B0;
    localparam logic [31:0] IMEM_NOP_WORD     = 32'h0000_0000;

    // MIPS encodings used to assemble test images
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_MUL   = 6'h02;

    function automatic logic [31:0] mk_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_rtype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [5:0] funct);
        return {op, rs, rt, rd, 5'd0, funct};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single synchronous-read word RAM with no reset so it maps onto
// block RAM; the read register holds its value when re_i is low.
module imem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory for the fetch stage: a load stream fills
// the RAM, then byte PCs are translated against BASE_ADDR with 1-cycle read latency.
module instr_mem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]   BASE_ADDR  = PC_WIDTH'(DEFAULT_BASE_ADDR),
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(IMEM_NOP_WORD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  reload,
    output logic                  load_done,
    output logic                  running,
    input  logic                  fetch_en,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  fault
);

    localparam int unsigned           DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned           SPAN_BYTES = DEPTH * 4;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);

    imem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic                  load_ready_q, load_ready_d;
    logic                  running_q, running_d;
    logic                  load_done_q, load_done_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fault_q, fault_d;

    logic                  load_hs;
    logic                  load_end;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [PC_WIDTH-1:0]   pc_off;
    logic                  pc_below;
    logic                  pc_misaligned;
    logic                  pc_past;
    logic                  pc_bad;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  run_fetch;

    // load_ready_q is only high in IDLE/LOAD, so a handshake never lands in RUN
    assign load_hs  = load_valid & load_ready_q;
    assign load_end = load_hs & (load_last | (wptr_q == LAST_IDX));

    // PC translation; an underflow wraps pc_off, so pc_below is checked separately
    assign pc_off        = pc - BASE_ADDR;
    assign pc_below      = (pc < BASE_ADDR);
    assign pc_misaligned = |pc[1:0];
    assign pc_past       = (64'(pc_off) >= 64'(SPAN_BYTES));
    assign pc_bad        = pc_below | pc_misaligned | pc_past;
    assign rd_idx        = pc_off[ADDR_WIDTH+1:2];
    assign run_fetch     = (state_q == RUN) & ~reload;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_hs) begin
                    state_d = load_end ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (load_end) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next-values
    always_comb begin
        load_ready_d  = (state_d != RUN);
        running_d     = (state_d == RUN);
        load_done_d   = (state_q != RUN) && (state_d == RUN);
        wptr_d        = wptr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        ram_re        = 1'b0;

        if ((state_q == RUN) && reload) begin
            wptr_d = '0;
        end else if (load_hs) begin
            wptr_d = load_end ? '0 : wptr_q + ADDR_WIDTH'(1);
        end

        // reload beats a concurrent fetch; outside RUN a fetch yields a clean NOP
        if (fetch_en) begin
            if (run_fetch && !pc_bad) begin
                instr_valid_d = 1'b1;
                fault_d       = 1'b0;
                ram_re        = 1'b1;
            end else if (run_fetch) begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end else begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b0;
            end
        end
    end

    // Output and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            load_ready_q  <= 1'b0;
            running_q     <= 1'b0;
            load_done_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            load_ready_q  <= load_ready_d;
            running_q     <= running_d;
            load_done_q   <= load_done_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (load_hs),
        .waddr_i (wptr_q),
        .wdata_i (load_data),
        .re_i    (ram_re),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    // RAM read register only drives instr for a legal fetch; otherwise NOP
    assign instr       = instr_valid_q ? ram_rdata : NOP_WORD;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign load_ready  = load_ready_q;
    assign running     = running_q;
    assign load_done   = load_done_q;

endmodule
